vga_timing_gen: RTL and testbench

- Generates 640x480@60Hz VGA raster timing from the 50 MHz system clock.
- Drives DrawX/DrawY into color_mapper and receives its Red/Green/Blue back.
- Gates that color with the blanking interval and presents sync, blank and pixel clock to the DAC/VGA pins.
- Upstream end of the DrawX/DrawY pixel-coordinate interface that color_mapper consumes.

---
 rtl/vga_timing_gen.sv | 145 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// 640x480@60Hz VGA raster timing from the 50 MHz system clock. Produces the
// DrawX/DrawY pixel coordinates consumed by color_mapper, gates the returned
// colour with the blanking interval and drives sync, blank and pixel clock to
// the DAC.
// Optional build macro: VGA_TIMING_PIPE_EN registers VGA_HS, VGA_VS,
// VGA_BLANK_N and VGA_R/G/B on pixel ticks, one pixel behind DrawX/DrawY, for
// colour sources that have one pixel of latency.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       pix_en,
    output logic       frame_end,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div;
    logic [9:0]       h;
    logic [9:0]       v;

    logic             hs_dec;
    logic             vs_dec;
    logic             blank_n_dec;
    logic [7:0]       r_dec;
    logic [7:0]       g_dec;
    logic [7:0]       b_dec;

    // The pixel tick is the last Clk of each pixel period; VGA_CLK is high in
    // the second half so its rising edge lands mid-pixel.
    assign pix_en     = (div == DIV_LAST);
    assign VGA_CLK    = (div >= DIV_HALF);
    assign frame_end  = pix_en && (h == H_LAST) && (v == V_LAST);
    assign DrawX      = h;
    assign DrawY      = v;
    assign VGA_SYNC_N = 1'b0;

    // Clock divider plus horizontal/vertical raster counters, stepping on pixel ticks
    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else if (pix_en) begin
            div <= '0;
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end else begin
            div <= div + DIV_ONE;
        end
    end

    // Sync, blank and colour gating decoded from the current raster position
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        hs_dec      = 1'b1;
        vs_dec      = 1'b1;
        blank_n_dec = 1'b0;
        if ((h >= H_SYNC_START) && (h < H_SYNC_END)) begin
            hs_dec = 1'b0;
        end
        if ((v >= V_SYNC_START) && (v < V_SYNC_END)) begin
            vs_dec = 1'b0;
        end
        if ((h < H_VIS) && (v < V_VIS)) begin
            blank_n_dec = 1'b1;
        end
        r_dec = blank_n_dec ? Red_in   : 8'h00;
        g_dec = blank_n_dec ? Green_in : 8'h00;
        b_dec = blank_n_dec ? Blue_in  : 8'h00;
    end

`ifdef VGA_TIMING_PIPE_EN
    // Register sync, blank and gated colour once per pixel, one pixel behind DrawX/DrawY
    always_ff @(posedge Clk) begin
        if (Reset) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= 8'h00;
            VGA_G       <= 8'h00;
            VGA_B       <= 8'h00;
        end else if (pix_en) begin
            VGA_HS      <= hs_dec;
            VGA_VS      <= vs_dec;
            VGA_BLANK_N <= blank_n_dec;
            VGA_R       <= r_dec;
            VGA_G       <= g_dec;
            VGA_B       <= b_dec;
        end
    end
`else
    // Zero-latency outputs straight from the decodes
    assign VGA_HS      = hs_dec;
    assign VGA_VS      = vs_dec;
    assign VGA_BLANK_N = blank_n_dec;
    assign VGA_R       = r_dec;
    assign VGA_G       = g_dec;
    assign VGA_B       = b_dec;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen. Horizontal timing uses the real
// 640x480 values; the vertical parameters are shrunk (4/1/2/2 lines) so that
// several whole frames fit in a short run. Expected outputs come from elapsed
// Clk cycles since reset: pixel index = t / CLK_DIV, position inside the frame
// follows from plain division and remainder.
module tb_vga_timing_gen;

    localparam int HV  = 640;
    localparam int HF  = 16;
    localparam int HSW = 96;
    localparam int HB  = 48;
    localparam int VV  = 4;
    localparam int VF  = 1;
    localparam int VSW = 2;
    localparam int VB  = 2;
    localparam int CD  = 2;
    localparam int HT  = HV + HF + HSW + HB;   // 800
    localparam int VT  = VV + VF + VSW + VB;   // 9
    localparam int FRAME = HT * VT * CD;       // 14400 Clk per frame

`ifdef VGA_TIMING_PIPE_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] red_in;
    logic [7:0] green_in;
    logic [7:0] blue_in;
    logic [9:0] draw_x;
    logic [9:0] draw_y;
    logic       pix_en;
    logic       frame_end;
    logic       vga_clk;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic       vga_sync_n;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .CLK_DIV(CD)
    ) dut (
        .Clk        (clk),
        .Reset      (reset),
        .Red_in     (red_in),
        .Green_in   (green_in),
        .Blue_in    (blue_in),
        .DrawX      (draw_x),
        .DrawY      (draw_y),
        .pix_en     (pix_en),
        .frame_end  (frame_end),
        .VGA_CLK    (vga_clk),
        .VGA_HS     (vga_hs),
        .VGA_VS     (vga_vs),
        .VGA_BLANK_N(vga_blank_n),
        .VGA_SYNC_N (vga_sync_n),
        .VGA_R      (vga_r),
        .VGA_G      (vga_g),
        .VGA_B      (vga_b)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       pe;
        logic       vclk;
        logic       fe;
        logic       hs;
        logic       vs;
        logic       bn;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    function automatic exp_t model_at(input int tt, input logic [7:0] ri, input logic [7:0] gi,
                                      input logic [7:0] bi);
        exp_t e;
        int   ph;
        int   fp;
        int   hx;
        int   vy;
        ph   = tt % CD;
        fp   = (tt / CD) % (HT * VT);
        hx   = fp % HT;
        vy   = fp / HT;
        e.x  = 10'(hx);
        e.y  = 10'(vy);
        e.pe = (ph == CD - 1);
        e.vclk = (ph >= CD / 2);
        e.fe = e.pe && (fp == HT * VT - 1);
        e.hs = !((hx >= HV + HF) && (hx < HV + HF + HSW));
        e.vs = !((vy >= VV + VF) && (vy < VV + VF + VSW));
        e.bn = (hx < HV) && (vy < VV);
        e.r  = e.bn ? ri : 8'h00;
        e.g  = e.bn ? gi : 8'h00;
        e.b  = e.bn ? bi : 8'h00;
        return e;
    endfunction

    int   t = 0;
    bit   model_ok = 1'b0;
    exp_t now_e;
    logic pipe_hs;
    logic pipe_vs;
    logic pipe_bn;
    logic [7:0] pipe_r;
    logic [7:0] pipe_g;
    logic [7:0] pipe_b;

    assign now_e = model_at(t, red_in, green_in, blue_in);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            t        <= 0;
            model_ok <= 1'b1;
            pipe_hs  <= 1'b1;
            pipe_vs  <= 1'b1;
            pipe_bn  <= 1'b0;
            pipe_r   <= 8'h00;
            pipe_g   <= 8'h00;
            pipe_b   <= 8'h00;
        end else if (model_ok) begin
            if (now_e.pe) begin
                pipe_hs <= now_e.hs;
                pipe_vs <= now_e.vs;
                pipe_bn <= now_e.bn;
                pipe_r  <= now_e.r;
                pipe_g  <= now_e.g;
                pipe_b  <= now_e.b;
            end
            t <= t + 1;
        end
    end

    logic       exp_hs;
    logic       exp_vs;
    logic       exp_bn;
    logic [7:0] exp_r;
    logic [7:0] exp_g;
    logic [7:0] exp_b;
`ifdef VGA_TIMING_PIPE_EN
    assign exp_hs = pipe_hs;
    assign exp_vs = pipe_vs;
    assign exp_bn = pipe_bn;
    assign exp_r  = pipe_r;
    assign exp_g  = pipe_g;
    assign exp_b  = pipe_b;
`else
    assign exp_hs = now_e.hs;
    assign exp_vs = now_e.vs;
    assign exp_bn = now_e.bn;
    assign exp_r  = now_e.r;
    assign exp_g  = now_e.g;
    assign exp_b  = now_e.b;
`endif

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (model_ok) begin
            check("draw_x",    draw_x,      now_e.x);
            check("draw_y",    draw_y,      now_e.y);
            check("pix_en",    pix_en,      now_e.pe);
            check("vga_clk",   vga_clk,     now_e.vclk);
            check("frame_end", frame_end,   now_e.fe);
            check("vga_hs",    vga_hs,      exp_hs);
            check("vga_vs",    vga_vs,      exp_vs);
            check("blank_n",   vga_blank_n, exp_bn);
            check("sync_n",    vga_sync_n,  1'b0);
            check("vga_rgb",   {vga_r, vga_g, vga_b}, {exp_r, exp_g, exp_b});
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_xy(input int x, input int y, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!((int'(draw_x) == x) && (int'(draw_y) == y)) && (n < 2 * FRAME)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2 * FRAME) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Wait for the sample where the outputs describe pixel (x, y)
    task automatic at_pixel(input int x, input int y, input string name);
        wait_xy(x, y, name);
        if (LAG != 0) repeat (CD) @(negedge clk);
    endtask

    task automatic run_to_frame_end(output int vs_lows, output bit found);
        int n;
        n       = 0;
        vs_lows = 0;
        found   = 1'b0;
        while (!found && (n < 2 * FRAME)) begin
            @(negedge clk);
            n++;
            if (vga_vs === 1'b0) vs_lows++;
            if (frame_end === 1'b1) found = 1'b1;
        end
        if (!found) check("frame_end_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int  changes;
        int  bad_steps;
        int  hs_lows;
        int  bn_highs;
        int  hs_fall_x;
        int  hs_rise_x;
        int  bn_fall_x;
        int  prev_x;
        logic prev_hs;
        logic prev_bn;
        int  vs_lows;
        bit  found;
        int  fe_cyc;
        int  rst_cyc;
        int  nonzero;
        int  n;

        reset    = 1'b1;
        red_in   = 8'h12;
        green_in = 8'h34;
        blue_in  = 8'h56;

        // Reset state while Reset is held
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_x",       draw_x,      10'd0);
        check("rst_y",       draw_y,      10'd0);
        check("rst_pix_en",  pix_en,      1'b0);
        check("rst_vga_clk", vga_clk,     1'b0);
        check("rst_fe",      frame_end,   1'b0);
        check("rst_hs",      vga_hs,      1'b1);
        check("rst_vs",      vga_vs,      1'b1);
        check("rst_bn",      vga_blank_n, (LAG != 0) ? 1'b0 : 1'b1);
        check("rst_r",       vga_r,       (LAG != 0) ? 8'h00 : 8'h12);
        @(posedge clk);
        #1 reset = 1'b0;

        // Line 0: DrawX sweep, HS pulse and blank edge
        changes   = 0;
        bad_steps = 0;
        hs_lows   = 0;
        bn_highs  = 0;
        hs_fall_x = -1;
        hs_rise_x = -1;
        bn_fall_x = -1;
        prev_x    = 0;
        prev_hs   = 1'b1;
        prev_bn   = 1'b0;
        for (int i = 0; i < HT * CD; i++) begin
            @(negedge clk);
            if (i == 0) check("first_pix_en_low", pix_en, 1'b0);
            if (i == 1) begin
                check("first_pix_en", pix_en, 1'b1);
                check("first_vclk",   vga_clk, 1'b1);
                check("first_x0",     draw_x, 10'd0);
            end
            if (i == 2) check("second_pixel_x", draw_x, 10'd1);
            if (i == HT * CD - 1) begin
                check("line0_last_x", draw_x, 10'd799);
                check("line0_last_y", draw_y, 10'd0);
            end
            if ((i > 0) && (int'(draw_x) != prev_x)) begin
                changes++;
                if (int'(draw_x) != prev_x + 1) bad_steps++;
            end
            if (vga_hs === 1'b0) hs_lows++;
            if (vga_blank_n === 1'b1) bn_highs++;
            if ((vga_hs === 1'b0) && (prev_hs === 1'b1) && (hs_fall_x < 0)) hs_fall_x = int'(draw_x);
            if ((vga_hs === 1'b1) && (prev_hs === 1'b0) && (hs_rise_x < 0)) hs_rise_x = int'(draw_x);
            if ((vga_blank_n === 1'b0) && (prev_bn === 1'b1) && (bn_fall_x < 0)) bn_fall_x = int'(draw_x);
            prev_x  = int'(draw_x);
            prev_hs = vga_hs;
            prev_bn = vga_blank_n;
        end
        check("x_changes",   changes,   799);
        check("x_bad_steps", bad_steps, 0);
        check("hs_low_clks", hs_lows,   192);
        check("bn_high_clks", bn_highs, 1280);
        check("hs_fall_x",   hs_fall_x, 656 + LAG);
        check("hs_rise_x",   hs_rise_x, 752 + LAG);
        check("bn_fall_x",   bn_fall_x, 640 + LAG);
        @(negedge clk);
        check("wrap_x", draw_x, 10'd0);
        check("wrap_y", draw_y, 10'd1);

        // Blank gating with constant white input
        red_in   = 8'hFF;
        green_in = 8'hFF;
        blue_in  = 8'hFF;
        at_pixel(0, VV - 1, "px_0_last_vis");
        check("rgb_0_last_vis", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
        at_pixel(0, VV, "px_0_first_blank");
        check("rgb_0_first_blank", {vga_r, vga_g, vga_b}, 24'h000000);

        wait_xy(0, 7, "line7");
        nonzero = 0;
        n = 0;
        while ((int'(draw_y) == 7) && (n < 2 * HT * CD)) begin
            if ({vga_r, vga_g, vga_b} !== 24'h000000) nonzero++;
            @(negedge clk);
            n++;
        end
        check("line7_len",     n,       HT * CD);
        check("line7_nonzero", nonzero, 0);

        // Frame timing: two consecutive frame_end pulses
        run_to_frame_end(vs_lows, found);
        fe_cyc = cyc;
        check("fe1_x", draw_x, 10'd799);
        check("fe1_y", draw_y, 10'(VT - 1));
        run_to_frame_end(vs_lows, found);
        check("fe_period", cyc - fe_cyc, FRAME);
        check("fe2_x",     draw_x, 10'd799);
        check("fe2_y",     draw_y, 10'(VT - 1));
        check("vs_low_clks", vs_lows, VSW * HT * CD);

        at_pixel(639, 0, "px_639_0");
        check("rgb_639_0", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
        at_pixel(640, 0, "px_640_0");
        check("rgb_640_0", {vga_r, vga_g, vga_b}, 24'h000000);

        // Mid-operation reset inside HS on the last vsync line
        wait_xy(700, VV + VF + VSW - 1, "mid_rst_pos");
        check("pre_rst_hs", vga_hs, 1'b0);
        check("pre_rst_vs", vga_vs, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        rst_cyc = cyc;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mrst_x",    draw_x,      10'd0);
        check("mrst_y",    draw_y,      10'd0);
        check("mrst_hs",   vga_hs,      1'b1);
        check("mrst_vs",   vga_vs,      1'b1);
        check("mrst_bn",   vga_blank_n, (LAG != 0) ? 1'b0 : 1'b1);
        check("mrst_vclk", vga_clk,     1'b0);
        run_to_frame_end(vs_lows, found);
        check("mrst_fe_delay", cyc - rst_cyc, FRAME);

`ifdef VGA_TIMING_PIPE_EN
        // One-pixel colour latency: value presented at DrawX=5 shows while DrawX=6
        wait_xy(5, 0, "pipe_x5");
        red_in = 8'h05;
        repeat (CD) @(negedge clk);
        check("pipe_x6", draw_x, 10'd6);
        check("pipe_r",  vga_r,  8'h05);
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
